// File: rtl/alu_exec_unit.sv
// Multi-cycle integer ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish in one cycle; shifts take one cycle per bit.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              out_valid_q;

  logic [XLEN-1:0]   alu_now_d;
  logic [XLEN-1:0]   shift_next_d;
  logic [4:0]        shamt_d;
  logic              start_shift_d;
  logic              accept_d;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Single-cycle result; shift codes only land here with a zero shift amount.
  function automatic logic [XLEN-1:0] alu_op(input logic [3:0]      op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One-bit step; SRA replicates the MSB, which stays the original sign bit.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      op,
                                                 input logic [XLEN-1:0] r);
    logic [XLEN-1:0] n;
    case (op)
      OP_SLL:  n = {r[XLEN-2:0], 1'b0};
      OP_SRL:  n = {1'b0, r[XLEN-1:1]};
      OP_SRA:  n = {r[XLEN-1], r[XLEN-1:1]};
      default: n = r;
    endcase
    return n;
  endfunction

  assign shamt_d       = operand_b[4:0];
  assign alu_now_d     = alu_op(alu_control, operand_a, operand_b);
  assign start_shift_d = is_shift_op(alu_control) && (shamt_d != 5'd0);
  assign shift_next_d  = shift_step(op_q, result_q);
  assign accept_d      = in_valid && (state_q == IDLE);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

  // Flush wins over every other transition and leaves result/zero untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= 5'd0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q <= alu_control;
            if (start_shift_d) begin
              state_q  <= SHIFT;
              result_q <= operand_a;
              cnt_q    <= shamt_d;
            end else begin
              state_q     <= DONE;
              result_q    <= alu_now_d;
              zero_q      <= (alu_now_d == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result_q <= shift_next_d;
          cnt_q    <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q     <= DONE;
            zero_q      <= (shift_next_d == '0);
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, hand-written corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return sa >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'd7 || c == 4'd8 || c == 4'd9) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive a request at a negedge in IDLE; returns at the negedge after acceptance.
  task automatic accept_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = c;
    operand_a   = a;
    operand_b   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid, scrambling inputs meanwhile.
  task automatic wait_valid(output int lat, output logic ready_bad);
    lat = 1;
    ready_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) ready_bad = 1'b1;
      in_valid    = 1'($urandom);
      alu_control = 4'($urandom);
      operand_a   = $urandom;
      operand_b   = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input int el);
    int   lat;
    logic rb;
    out_ready = 1'b1;
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    accept_op(c, a, b);
    wait_valid(lat, rb);
    check({nm, " latency"}, 32'(lat), 32'(el));
    check({nm, " result"}, result, er);
    check({nm, " zero"}, 32'(zero), 32'(ez));
    check({nm, " busy_while_pending"}, 32'(rb), 32'd0);
    @(negedge clk);
    check({nm, " back_to_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          lat;
    logic        rb;
    logic [31:0] held;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        bad;

    vecs.push_back('{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1});
    vecs.push_back('{4'd1,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1});
    vecs.push_back('{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{4'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32});
    vecs.push_back('{4'd7,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1});
    vecs.push_back('{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1});
    vecs.push_back('{4'd3,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1});
    vecs.push_back('{4'd4,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{4'd12, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{4'd9,  32'h8000_0010, 32'h0000_0023, 32'hF000_0002, 1'b0, 4});
    vecs.push_back('{4'd7,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32});
    vecs.push_back('{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back('{4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 1'b0, 5});

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 4'd0; operand_a = 32'd0; operand_b = 32'd0;
    #3;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b,
             vecs[i].r, vecs[i].z, vecs[i].lat);

    // Consumer stalls for 5 cycles in DONE with a new request pending.
    out_ready = 1'b0;
    accept_op(4'd0, 32'd5, 32'd6);
    wait_valid(lat, rb);
    check("stall latency", 32'(lat), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; alu_control = 4'd1; operand_a = $urandom; operand_b = $urandom;
      if (!out_valid || result !== 32'd11 || in_ready || zero) bad = 1'b1;
      @(negedge clk);
    end
    check("stall held", 32'(bad), 32'd0);
    check("stall result", result, 32'd11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall release out_valid", 32'(out_valid), 32'd0);
    check("stall release in_ready", 32'(in_ready), 32'd1);

    // Flush during a 20-bit SLL, asserted in the fifth cycle after accept.
    accept_op(4'd7, 32'h0000_0001, 32'd20);
    repeat (4) @(negedge clk);
    held = result;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush shift busy", 32'(busy), 32'd0);
    check("flush shift in_ready", 32'(in_ready), 32'd1);
    check("flush shift result kept", result, held);
    bad = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid || busy) bad = 1'b1;
      @(negedge clk);
    end
    check("flush no out_valid pulse", 32'(bad), 32'd0);
    run_op("post-flush add", 4'd0, 32'd100, 32'd23, 32'd123, 1'b0, 1);

    // Flush and in_valid together in IDLE: nothing is accepted.
    flush = 1'b1; in_valid = 1'b1; alu_control = 4'd0; operand_a = 32'd1; operand_b = 32'd2;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush+valid busy", 32'(busy), 32'd0);
    check("flush+valid out_valid", 32'(out_valid), 32'd0);

    // Flush in DONE drops out_valid but keeps the result.
    out_ready = 1'b0;
    accept_op(4'd0, 32'd3, 32'd4);
    wait_valid(lat, rb);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush done out_valid", 32'(out_valid), 32'd0);
    check("flush done result", result, 32'd7);
    check("flush done busy", 32'(busy), 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset while in DONE, between clock edges.
    out_ready = 1'b0;
    accept_op(4'd0, 32'h10, 32'h20);
    wait_valid(lat, rb);
    check("pre-reset result", result, 32'h30);
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset result", result, 32'd0);
    check("async reset zero", 32'(zero), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    run_op("post-reset code1100", 4'd12, 32'hCAFE_F00D, 32'h0000_0003, 32'd0, 1'b1, 1);

    // Asynchronous reset in the middle of a shift.
    accept_op(4'd8, 32'hFFFF_FFFF, 32'd10);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset mid-shift busy", 32'(busy), 32'd0);
    check("reset mid-shift result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      er = model(c, a, b);
      run_op($sformatf("rand%0d op%0d", i, c), c, a, b, er, (er == 32'd0), model_lat(c, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; shift amount is always operand_b[4:0].
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of the in-flight operation.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-007 SHALL have port alu_control  input  4  operation code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
REQ-008 SHALL have port operand_a  input  XLEN  first operand.
REQ-009 SHALL have port operand_b  input  XLEN  second operand.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  registered result.
REQ-013 SHALL have port zero  output  1  registered flag, 1 when result is all zeros.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-016 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready at a rising edge, latching alu_control, operand_a and operand_b.
REQ-017 SHALL, for non-shift codes or any shift with shamt==0, load result and zero at the accept edge and enter DONE, giving out_valid on the cycle after the accept (latency 1).
REQ-018 SHALL, for SLL/SRL/SRA with shamt>0, enter SHIFT with result=operand_a and counter=shamt, shifting result by one bit per cycle and decrementing the counter.
REQ-019 SHALL, in SHIFT, perform the shift that brings the counter to 0 on the same edge that enters DONE (out_valid on cycle shamt+1 after the accept; 32 cycles for shamt=31).
REQ-020 SHALL fill SRA shifts with the original sign bit, and fill SLL and SRL shifts with zeros.
REQ-021 SHALL wrap ADD and SUB modulo 2^XLEN, with no carry or overflow output.
REQ-022 SHALL set SLT result to 1 when operand_a < operand_b compared as signed values, and set SLTU result to 1 when operand_a < operand_b compared as unsigned values; otherwise the result is 0, zero-extended to XLEN.
REQ-023 SHALL, for codes 1010-1111, produce result 0 and zero 1 with latency 1; such codes never hang the unit.
REQ-024 SHALL hold out_valid, result and zero stable in DONE until out_ready is sampled high, then return to IDLE on that edge.
REQ-025 SHALL leave a one-cycle IDLE bubble between back-to-back operations; no accept is allowed in DONE.
REQ-026 SHALL ignore in_valid and input changes while busy; latched operands alone drive the computation.
REQ-027 SHALL, on flush high at a rising edge in any state, enter IDLE, clear out_valid, and keep result and zero unchanged; flush has priority over accept and out_ready.
REQ-028 SHALL NOT accept a new operation when flush and in_valid are high in the same IDLE cycle.
REQ-029 SHALL update zero at the same edge as the final value of result.

Reset
REQ-030 SHALL, on reset assertion, set the state to IDLE, out_valid 0, result 0, zero 0, busy 0 and the counter 0, without waiting for a clock edge.
REQ-031 SHALL, when reset is asserted mid-SHIFT or in DONE, abandon the operation; after reset release, in_ready is 1 on the first cycle.

Verification
REQ-032 SHALL be verified with: ADD, a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept, result 0x80000000, zero 0.
REQ-033 SHALL be verified with: SUB, a=b=0x1234 -> result 0, zero 1; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-034 SHALL be verified with: SRA, a=0x80000000, b=31 -> busy for 32 cycles, result 0xFFFFFFFF; SRL with the same operands -> 0x00000001; SLL with b=0 -> latency 1, result=a.
REQ-035 SHALL be verified with: out_ready held low for 5 cycles in DONE -> result stable and out_valid high throughout, in_ready 0; out_ready high -> IDLE next cycle.
REQ-036 SHALL be verified with: flush during SHIFT (SLL b=20, flush at cycle 5) -> IDLE next cycle, no out_valid pulse; a new ADD is then accepted normally.
REQ-037 SHALL be verified with: reset pulse asserted between clock edges while in DONE -> out_valid, result and zero drop to 0 immediately; code 1100 after reset -> result 0, zero 1, latency 1.
